ifetch_prefetch: RTL
====================

// Module: ifetch_prefetch
// PURPOSE
//  Instruction fetch/prefetch stage feeding the decode/IR input of the single-cycle core.
//  Streams sequential instruction words from a pipelined instruction memory with a req/gnt/rvalid handshake.
//  Buffers up to DEPTH words, each with its PC, in an in-order queue.
//  Core consumes words via valid/ready; on a taken branch/jump the core issues a redirect, which flushes the queue and discards in-flight words.
// PARAMETERS
//  DEPTH     4             queue entries; also the max outstanding memory requests (power of 2, >=2)
//  RESET_PC  32'h0000_3000 fetch address after reset
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  redirect_valid  in   1   core requests fetch restart (branch/jump taken)
//  redirect_pc     in   32  new fetch address; bits [1:0] ignored (forced 0)
//  mem_req         out  1   request to instruction memory
//  mem_addr        out  32  word address of request (bits [1:0] = 0)
//  mem_gnt         in   1   request accepted this cycle when mem_req & mem_gnt
//  mem_rvalid      in   1   read data valid; responses in request order, >=1 cycle after grant
//  mem_rdata       in   32  instruction word
//  inst_valid      out  1   queue head holds a valid instruction
//  inst            out  32  head instruction word
//  inst_pc         out  32  PC of head instruction
//  inst_ready      in   1   core accepts head when inst_valid & inst_ready
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. On rst: fetch_pc=RESET_PC; count=0; outst=0; drop=0.
//    mem_req=0 and inst_valid=0 while rst is high.
//  - Invariant: count + outst <= DEPTH. Slots are reserved at grant, so a response never overflows the queue.
//  - mem_req = !redirect_valid & (count + outst < DEPTH), combinational; mem_addr = fetch_pc.
//    First request is in the first cycle after rst deasserts.
//  - On grant: fetch_pc += 4 (wraps modulo 2^32); outst += 1.
//  - On mem_rvalid (outst>0): outst -= 1. If drop>0: drop -= 1 and discard the data.
//    Otherwise push {fetch-order PC, mem_rdata}. Pushed PC comes from a separate tail_pc register, advanced by 4 per push.
//  - mem_rvalid with outst==0 is a protocol error and is ignored: no state change.
//  - inst_valid = (count != 0). inst/inst_pc are driven from the head entry, with no added latency.
//    Best case, a word reaches inst one cycle after its mem_rvalid.
//  - Pop on inst_valid & inst_ready. Push and pop in the same cycle leave count unchanged.
//  - Redirect (highest priority):
//    - queue cleared (count=0, pointers reset); fetch_pc and tail_pc = {redirect_pc[31:2],2'b00};
//    - drop = outst - (mem_rvalid ? 1 : 0), and outst is updated the same way;
//    - mem_req=0 that cycle, and any pop or push that cycle is void;
//    - fetch resumes the next cycle at the new PC.
//  - Redirect while drop>0 accumulates: drop takes the full post-cycle outst, and all older responses are discarded.
//  - Back-to-back redirects: each one restarts; only the last redirect_pc is fetched.
//  - mem_req may be withdrawn when the queue fills, or on redirect, even without a grant. Memory must treat ungranted requests as not issued.
// STRUCTURE
//  - Shared define header: `IFP_RESET_PC, and the instruction width/PC width defines already used by the core.
//  - Sub-module pf_queue: synchronous FIFO, DEPTH x 64 bits ({pc, inst}), with push, pop and flush inputs and count/empty/full outputs.
//    Flush has priority over push/pop.
//  - Top level holds fetch_pc, tail_pc, the outst/drop counters ($clog2(DEPTH)+1 bits) and the issue logic.
// TESTING
//  1. Reset, then memory with gnt=1 and 1-cycle latency, core ready=1:
//     mem_addr 0x3000, 0x3004, ...; inst_pc follows the same sequence with no gaps after fill.
//  2. inst_ready=0 for 10 cycles: exactly 4 grants (0x3000..0x300C), mem_req then held 0.
//     On release, words pop in order with no loss.
//  3. 3 requests in flight, redirect_pc=0x3403 asserted: queue empties and the next mem_addr is 0x3400.
//     The 3 stale responses are dropped; the first inst_pc is 0x3400.
//  4. Redirect in the same cycle as a mem_rvalid, with outst=2: that response and one more are dropped (drop=1), and outst=1 after that cycle.
//  5. fetch_pc=0xFFFF_FFFC: the next request address wraps to 0x0000_0000.
//  6. rst asserted mid-stream with 2 outstanding: outputs go to 0 immediately.
//     After release, mem_addr=0x3000, and a spurious rvalid with outst==0 is ignored.

Source files
------------

// File: rtl/ifetch_prefetch_pkg.sv
// ifetch_prefetch_pkg
//   Shared types and constants for the instruction fetch/prefetch stage.
//   IFP_RESET_PC : fetch address used after reset
//   IFP_XLEN     : PC width
//   IFP_ILEN     : instruction word width
//   ifp_entry_t  : one prefetch queue entry, {pc, inst}
package ifetch_prefetch_pkg;

  localparam int IFP_XLEN = 32;
  localparam int IFP_ILEN = 32;
  localparam logic [IFP_XLEN-1:0] IFP_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [IFP_XLEN-1:0] pc;
    logic [IFP_ILEN-1:0] inst;
  } ifp_entry_t;

  // Instruction fetches are always word aligned; the two low bits of any
  // incoming target address are simply forced to zero.
  function automatic logic [IFP_XLEN-1:0] ifp_word_align(input logic [IFP_XLEN-1:0] a);
    return {a[IFP_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pf_queue.sv
// pf_queue
//   Synchronous in-order FIFO holding prefetched {pc, inst} entries.
//   Flush has priority over push and pop; head data is read combinationally.
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_flush          empty the queue (pointers and count back to zero)
//   i_push           write i_push_data at the tail (ignored when full, unless popping)
//   i_push_data      entry to write
//   i_pop            drop the head entry (ignored when empty)
//   o_head           current head entry
//   o_count          number of valid entries
//   o_empty, o_full  status flags
module pf_queue
  import ifetch_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  ifp_entry_t    i_push_data,
  input  logic          i_pop,
  output ifp_entry_t    o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  ifp_entry_t    r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue can still take a push in a cycle where the head leaves.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
//   Fetch/prefetch stage: streams sequential words from a pipelined
//   instruction memory into an in-order queue and presents the head
//   entry to the core. A redirect flushes the queue and arranges for the
//   responses still in flight to be discarded.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   redirect_valid/_pc        restart fetch at redirect_pc (low two bits ignored)
//   mem_req/mem_addr          request and word address to instruction memory
//   mem_gnt                   request accepted when mem_req & mem_gnt
//   mem_rvalid/mem_rdata      in-order read response
//   inst_valid/inst/inst_pc   head of the queue
//   inst_ready                core accepts the head
// Handshakes: a request transfers on a cycle with mem_req & mem_gnt, an
// instruction transfers on a cycle with inst_valid & inst_ready; nothing
// transfers otherwise, and mem_req may drop without a grant.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFP_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_tail_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic          w_q_empty;
  logic          w_q_full;
  ifp_entry_t    w_head;
  ifp_entry_t    w_push_data;
  logic [CW:0]   w_inflight;
  logic          w_grant;
  logic          w_rsp;
  logic          w_dropping;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_outst_after_rsp;

  // Queue slots are reserved at grant time: count + outst never exceeds
  // DEPTH, so a response always has room when it arrives.
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outst};
  assign mem_req    = ~rst & ~redirect_valid & (w_inflight < (CW+1)'(DEPTH));
  assign mem_addr   = r_fetch_pc;
  assign w_grant    = mem_req & mem_gnt;

  // A response with nothing outstanding is a memory protocol error; it is
  // ignored completely.
  assign w_rsp      = mem_rvalid & (r_outst != '0);
  assign w_dropping = (r_drop != '0);
  assign w_push     = w_rsp & ~w_dropping & ~redirect_valid & ~w_q_full;
  assign w_pop      = inst_valid & inst_ready & ~redirect_valid;

  assign w_outst_after_rsp = r_outst - CW'(w_rsp);

  assign w_push_data.pc   = r_tail_pc;
  assign w_push_data.inst = mem_rdata;

  assign inst_valid = ~rst & ~w_q_empty;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_tail_pc  <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old
      // stream, including any earlier drop backlog, so drop is simply the
      // post-cycle outstanding count.
      r_fetch_pc <= ifp_word_align(redirect_pc);
      r_tail_pc  <= ifp_word_align(redirect_pc);
      r_outst    <= w_outst_after_rsp;
      r_drop     <= w_outst_after_rsp;
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outst <= r_outst + CW'(w_grant) - CW'(w_rsp);
      if (w_rsp && w_dropping) r_drop <= r_drop - CW'(1);
      // tail_pc tracks the PC of the next word to be queued, independent of
      // fetch_pc, which has already run ahead by the outstanding requests.
      if (w_push) r_tail_pc <= r_tail_pc + 32'd4;
    end
  end

  pf_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_q_empty),
    .o_full      (w_q_full)
  );

endmodule
